// File: rtl/ir_receiver_if.sv
// ir_receiver_if: groups the IR receiver pin input and its decoded-letter outputs.
// Ports: signal_in (raw demodulator level), data_out / data_valid_out (decoded letter),
//        busy_out (frame in progress), error_out (frame abort pulse).
interface ir_receiver_if #(
  parameter int MESSAGE_LENGTH = 5
);
  logic                      signal_in;
  logic [MESSAGE_LENGTH-1:0] data_out;
  logic                      data_valid_out;
  logic                      busy_out;
  logic                      error_out;

  // master: the receiver itself; slave: the pin driver / letter consumer side.
  modport master (
    input  signal_in,
    output data_out, data_valid_out, busy_out, error_out
  );
  modport slave (
    output signal_in,
    input  data_out, data_valid_out, busy_out, error_out
  );
endinterface

// File: rtl/ir_receiver.sv
// ir_receiver: decodes the IR pulse-width frame (4T start mark, then LSB-first bits,
//   each a 1T space plus a 1T(=0)/2T(=1) mark) into a MESSAGE_LENGTH-bit letter code.
// Latency: data_valid_out 3 clk_in cycles after the final mark ends (+16 with the filter);
//   no backpressure, every data_valid_out / error_out pulse must be taken by the consumer.
// Ports: clk_in, rst_in (async active-low), rx (ir_receiver_if.master).
// Option: define IR_RX_GLITCH_FILTER_EN to add a 16-cycle glitch filter after the synchronizer.
module ir_receiver #(
  parameter int MESSAGE_LENGTH = 5,
  parameter int UNIT_CYCLES    = 60000,
  parameter bit ACTIVE_LOW_IN  = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  ir_receiver_if.master rx
);
  localparam int CNT_W = $clog2(5 * UNIT_CYCLES) + 1;
  localparam int LEN_W = CNT_W + 1;
  localparam int IDX_W = (MESSAGE_LENGTH > 1) ? $clog2(MESSAGE_LENGTH) : 1;

  // Classification thresholds in half-unit steps, fixed at elaboration.
  localparam logic [LEN_W-1:0] L_0P5 = LEN_W'(UNIT_CYCLES / 2);
  localparam logic [LEN_W-1:0] L_1P5 = LEN_W'((3 * UNIT_CYCLES) / 2);
  localparam logic [LEN_W-1:0] L_2P0 = LEN_W'(2 * UNIT_CYCLES);
  localparam logic [LEN_W-1:0] L_2P5 = LEN_W'((5 * UNIT_CYCLES) / 2);
  localparam logic [LEN_W-1:0] L_3P5 = LEN_W'((7 * UNIT_CYCLES) / 2);
  localparam logic [LEN_W-1:0] L_4P5 = LEN_W'((9 * UNIT_CYCLES) / 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(5 * UNIT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MESSAGE_LENGTH - 1);
  // Pin level when no mark is present; synchronizer resets to it so reset is not seen as an edge.
  localparam logic IDLE_LVL = ACTIVE_LOW_IN;

  typedef enum logic [1:0] {S_IDLE, S_START_MARK, S_SPACE, S_BIT_MARK} state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync2_q;
  logic                      lvl;
  logic                      mark, mark_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [MESSAGE_LENGTH-1:0] shreg_q, shreg_d;
  logic [MESSAGE_LENGTH-1:0] data_q, data_d;
  logic                      dv_q, dv_d;
  logic                      err_q, err_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= rx.signal_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  // Level follows the synchronized input only after 16 consecutive cycles at the new level.
  logic       filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == 4'd15) filt_d = sync2_q;
      else                 fcnt_d = fcnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      filt_q <= IDLE_LVL;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign mark = lvl ^ ACTIVE_LOW_IN;

  logic             mark_rise, mark_fall;
  logic [LEN_W-1:0] len;
  logic             is_bit0, is_bit1, is_start;

  assign mark_rise = mark & ~mark_q;
  assign mark_fall = ~mark & mark_q;
  // Counter is cleared in the edge cycle, so it lags the true width by one.
  assign len      = {1'b0, cnt_q} + 1'b1;
  assign is_bit0  = (len >= L_0P5) && (len < L_1P5);
  assign is_bit1  = (len >= L_1P5) && (len < L_2P5);
  assign is_start = (len >= L_3P5) && (len < L_4P5);

  always_comb begin
    cnt_d = cnt_q;
    if (mark_rise || mark_fall) cnt_d = '0;
    else if (cnt_q != CNT_SAT)  cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mark_rise) state_d = S_START_MARK;
      end
      S_START_MARK: begin
        if (mark_fall) begin
          // A non-start width here is line noise: drop it without reporting.
          if (is_start) begin
            state_d = S_SPACE;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SPACE: begin
        if (len >= L_2P0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (mark_rise) begin
          state_d = S_BIT_MARK;
        end
      end
      S_BIT_MARK: begin
        if (mark_fall) begin
          if (is_start) begin
            // Start mark mid-frame: abort this frame but resync onto the new one.
            err_d   = 1'b1;
            state_d = S_SPACE;
            idx_d   = '0;
          end else if (!(is_bit0 || is_bit1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            shreg_d[idx_q] = is_bit1;
            if (idx_q == IDX_LAST) begin
              data_d  = shreg_d;
              dv_d    = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SPACE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      mark_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mark_q  <= mark;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign rx.data_out       = data_q;
  assign rx.data_valid_out = dv_q;
  assign rx.error_out      = err_q;
  assign rx.busy_out       = (state_q != S_IDLE);
endmodule
